// File: rtl/async_rr_arbiter.sv
// Round-robin share of one req/ack upstream source among num_req requesters, one transaction at a time.
// IDLE->REQ->LOAD->ACK: 4 cycles plus upstream ack latency; upstream stalls hold req_up with no timeout.
module async_rr_arbiter #(
    parameter  int num_req    = 4,
    parameter  int data_width = 32,
    localparam int gw         = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [num_req-1:0]    req_in,
    output logic [num_req-1:0]    ack_out,
    output logic [data_width-1:0] dout,
    output logic                  req_up,
    input  logic                  ack_up,
    input  logic [data_width-1:0] din_up,
    output logic [gw-1:0]         grant_idx,
    output logic                  busy,
    output logic [31:0]           xfer_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [gw-1:0]           last, last_nxt;
    logic [gw-1:0]           grant_nxt;
    logic [gw-1:0]           pick;
    logic [num_req-1:0]      onehot;
    logic [num_req-1:0]      ack_nxt;
    logic [data_width-1:0]   dout_nxt;
    logic                    req_up_nxt;
    logic [31:0]             count_nxt;

    // Requester j sits (j - last - 1) mod num_req places after the pointer; nearest active one wins.
    always_comb begin
        int best_d;
        int d;
        best_d = num_req;
        d      = 0;
        pick   = last;
        for (int j = 0; j < num_req; j++) begin
            d = (j - int'(last) - 1 + num_req) % num_req;
            if (req_in[j] && (d < best_d)) begin
                best_d = d;
                pick   = gw'(j);
            end
        end
    end

    always_comb begin
        onehot = '0;
        for (int j = 0; j < num_req; j++) begin
            onehot[j] = (grant_idx == gw'(j));
        end
    end

    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        grant_nxt  = grant_idx;
        req_up_nxt = req_up;
        dout_nxt   = dout;
        ack_nxt    = '0;
        count_nxt  = xfer_count;
        case (state)
            IDLE: begin
                if (|req_in) begin
                    grant_nxt  = pick;
                    last_nxt   = pick;
                    req_up_nxt = 1'b1;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                if (ack_up) begin
                    req_up_nxt = 1'b0;
                    dout_nxt   = din_up;
                    state_nxt  = LOAD;
                end
            end
            // dout has been stable a full cycle before ack rises.
            LOAD: begin
                ack_nxt   = onehot;
                state_nxt = ACK;
            end
            ACK: begin
                count_nxt = xfer_count + 32'd1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= gw'(num_req - 1);
            grant_idx  <= '0;
            req_up     <= 1'b0;
            dout       <= '0;
            ack_out    <= '0;
            xfer_count <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            grant_idx  <= grant_nxt;
            req_up     <= req_up_nxt;
            dout       <= dout_nxt;
            ack_out    <= ack_nxt;
            xfer_count <= count_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_async_rr_arbiter.sv
// Directed and random traffic against a transaction-level arbiter model, compared every cycle.
module tb_async_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int GW = 2;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_in;
    logic [NR-1:0] ack_out;
    logic [DW-1:0] dout;
    logic          req_up;
    logic          ack_up;
    logic [DW-1:0] din_up;
    logic [GW-1:0] grant_idx;
    logic          busy;
    logic [31:0]   xfer_count;

    async_rr_arbiter #(.num_req(NR), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out), .dout(dout),
        .req_up(req_up), .ack_up(ack_up), .din_up(din_up), .grant_idx(grant_idx),
        .busy(busy), .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 waiting on upstream, 2 data held, 3 ack pulse.
    int            m_phase = 0;
    int            m_last  = NR - 1;
    int            m_grant = 0;
    logic [NR-1:0] m_ack   = '0;
    logic [DW-1:0] m_dout  = '0;
    logic          m_req_up = 1'b0;
    logic          m_busy  = 1'b0;
    logic [31:0]   m_count = '0;

    always @(posedge clk) begin
        int pk;
        int k;
        logic [NR-1:0] rv;
        if (rst) begin
            m_phase <= 0; m_last <= NR - 1; m_grant <= 0; m_ack <= '0;
            m_dout <= '0; m_req_up <= 1'b0; m_busy <= 1'b0; m_count <= '0;
        end else begin
            case (m_phase)
                0: begin
                    pk = -1;
                    rv = req_in;
                    for (int d = 1; d <= NR; d++) begin
                        k = (m_last + d) % NR;
                        if (pk < 0 && rv[k[GW-1:0]]) pk = k;
                    end
                    if (pk >= 0) begin
                        m_grant <= pk; m_last <= pk; m_req_up <= 1'b1;
                        m_phase <= 1; m_busy <= 1'b1;
                    end
                end
                1: if (ack_up) begin
                    m_req_up <= 1'b0; m_dout <= din_up; m_phase <= 2;
                end
                2: begin
                    m_ack <= NR'(1) << m_grant; m_phase <= 3;
                end
                default: begin
                    m_ack <= '0; m_count <= m_count + 32'd1; m_phase <= 0; m_busy <= 1'b0;
                end
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    // Agent knobs and logs
    int p_delay = 0, p_rand = 0, p_val = 0, p_cnt = 0;
    int c_rand = 0, target = 0, total_acks = 0, ack_hi = 0;
    bit rereq = 0, strict = 0;
    int glog[$];
    int rxq[NR][$];
    int vcount[int];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("ack_out",    64'(ack_out),    64'(m_ack));
        check("dout",       64'(dout),       64'(m_dout));
        check("req_up",     64'(req_up),     64'(m_req_up));
        check("grant_idx",  64'(grant_idx),  64'(m_grant));
        check("busy",       64'(busy),       64'(m_busy));
        check("xfer_count", 64'(xfer_count), 64'(m_count));
    endtask

    task automatic agents();
        logic [NR-1:0] acked;
        int v;
        acked = ack_out;
        if (ack_up) begin
            ack_up = 1'b0;
        end else if (req_up) begin
            if (p_cnt >= p_delay && $urandom_range(99) >= p_rand) begin
                ack_up = 1'b1; din_up = p_val; p_val++; p_cnt = 0;
            end else begin
                p_cnt++;
            end
        end else begin
            p_cnt = 0;
        end
        if (acked != '0) ack_hi++;
        for (int k = 0; k < NR; k++) begin
            if (acked[k]) begin
                v = int'(dout);
                glog.push_back(k);
                rxq[k].push_back(v);
                total_acks++;
                if (strict) begin
                    check("ack_without_req", 64'(req_in[k]), 64'd1);
                    check("value_duplicate", 64'(vcount.exists(v)), 64'd0);
                    vcount[v] = 1;
                end
                req_in[k] = 1'b0;
            end
        end
        if (total_acks >= target) begin
            req_in = '0;
        end else if (rereq) begin
            for (int k = 0; k < NR; k++)
                if (!req_in[k] && !acked[k] && $urandom_range(99) >= c_rand) req_in[k] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        agents();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        glog.delete();
        for (int k = 0; k < NR; k++) rxq[k].delete();
        vcount.delete();
        total_acks = 0; ack_hi = 0; p_cnt = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acks(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (total_acks < n && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(total_acks >= n), 64'd1);
    endtask

    initial begin
        int held;
        rst = 1'b1; req_in = '0; ack_up = 1'b0; din_up = '0;
        ticks(2);
        check("rst_ack_out", 64'(ack_out), 64'd0);
        check("rst_req_up", 64'(req_up), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_xfer_count", 64'(xfer_count), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        rst = 1'b0;
        clear_logs();

        // 1: single requester 2, producer acks one cycle after req with 7
        p_delay = 0; p_rand = 0; p_val = 7; target = 1; rereq = 0; strict = 0;
        req_in = 4'b0100;
        wait_acks("t1_timeout", 1, 50);
        ticks(2);
        check("t1_ack_count", 64'(glog.size()), 64'd1);
        check("t1_grant_log", 64'(glog[0]), 64'd2);
        check("t1_rx_value", 64'(rxq[2][0]), 64'd7);
        check("t1_dout", 64'(dout), 64'd7);
        check("t1_grant_idx", 64'(grant_idx), 64'd2);
        check("t1_xfer_count", 64'(xfer_count), 64'd1);
        check("t1_ack_width", 64'(ack_hi), 64'd1);

        // 2: all four re-requesting, producer counting from 0
        reset_dut();
        p_val = 0; target = 6; rereq = 1; c_rand = 0;
        req_in = 4'b1111;
        wait_acks("t2_timeout", 6, 200);
        ticks(3);
        check("t2_ack_count", 64'(glog.size()), 64'd6);
        for (int i = 0; i < 6; i++) check("t2_grant_order", 64'(glog[i]), 64'(i % 4));
        check("t2_rx0_a", 64'(rxq[0][0]), 64'd0);
        check("t2_rx0_b", 64'(rxq[0][1]), 64'd4);
        check("t2_rx1_a", 64'(rxq[1][0]), 64'd1);
        check("t2_rx1_b", 64'(rxq[1][1]), 64'd5);
        check("t2_rx2", 64'(rxq[2][0]), 64'd2);
        check("t2_rx3", 64'(rxq[3][0]), 64'd3);
        check("t2_xfer_count", 64'(xfer_count), 64'd6);

        // 3: after grant 2, requesters 0 and 3 together -> 3 then 0
        reset_dut();
        rereq = 0; target = 3;
        req_in = 4'b0100;
        wait_acks("t3a_timeout", 1, 50);
        req_in = 4'b1001;
        wait_acks("t3b_timeout", 3, 100);
        check("t3_grant_a", 64'(glog[0]), 64'd2);
        check("t3_grant_b", 64'(glog[1]), 64'd3);
        check("t3_grant_c", 64'(glog[2]), 64'd0);

        // 4: upstream withholds ack for 10 cycles, then a spurious ack in IDLE
        reset_dut();
        p_delay = 10; p_val = 100; target = 1;
        req_in = 4'b0001;
        tick();
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_up && busy && ack_out == '0) held++;
            tick();
        end
        check("t4_held_cycles", 64'(held), 64'd10);
        wait_acks("t4_timeout", 1, 50);
        ticks(3);
        check("t4_xfer_count", 64'(xfer_count), 64'd1);
        check("t4_rx_value", 64'(rxq[0][0]), 64'd100);
        ack_up = 1'b1; din_up = 32'h0000_dead;
        ticks(2);
        check("t4_spurious_dout", 64'(dout), 64'd100);
        check("t4_spurious_busy", 64'(busy), 64'd0);
        check("t4_spurious_req_up", 64'(req_up), 64'd0);
        check("t4_spurious_count", 64'(xfer_count), 64'd1);

        // 4b: granted requester drops its request mid-transaction
        reset_dut();
        p_delay = 3; p_val = 200; target = 1;
        req_in = 4'b0010;
        tick();
        req_in = '0;
        wait_acks("t4b_timeout", 1, 50);
        ticks(2);
        check("t4b_grant", 64'(glog[0]), 64'd1);
        check("t4b_value", 64'(rxq[1][0]), 64'd200);
        check("t4b_xfer_count", 64'(xfer_count), 64'd1);

        // 5: reset while waiting on upstream
        reset_dut();
        p_delay = 1000; target = 1;
        req_in = 4'b0100;
        ticks(3);
        check("t5_pre_req_up", 64'(req_up), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_req_up", 64'(req_up), 64'd0);
        check("t5_ack_out", 64'(ack_out), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_xfer_count", 64'(xfer_count), 64'd0);
        clear_logs();
        p_delay = 0; p_val = 300; target = 1;
        req_in = 4'b1111;
        wait_acks("t5_timeout", 1, 50);
        check("t5_first_grant", 64'(glog[0]), 64'd0);
        check("t5_value", 64'(rxq[0][0]), 64'd300);

        // 6: random stalls on both sides, 5000 items
        reset_dut();
        p_delay = 0; p_rand = 30; c_rand = 30; p_val = 0;
        rereq = 1; strict = 1; target = 5000;
        req_in = '0;
        wait_acks("t6_timeout", 5000, 60000);
        ticks(8);
        check("t6_xfer_count", 64'(xfer_count), 64'd5000);
        check("t6_distinct_values", 64'(vcount.num()), 64'd5000);
        check("t6_produced", 64'(p_val), 64'd5000);
        check("t6_final_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
